// File: rtl/fu_sequencer.sv
// Sequences single-pass ops and a 32-step shift-add multiply over an external function unit.
// Latency: single-pass accept N -> rsp_valid N+2, MUL accept N -> rsp_valid N+65; response held until rsp_ready.
module fu_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int SHIFTER_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [4:0]               req_op,
  input  logic [DATA_WIDTH-1:0]    req_a,
  input  logic [DATA_WIDTH-1:0]    req_b,
  input  logic [SHIFTER_WIDTH-1:0] req_sh,
  output logic [3:0]               fu_sel,
  output logic [DATA_WIDTH-1:0]    fu_a,
  output logic [DATA_WIDTH-1:0]    fu_b,
  output logic [SHIFTER_WIDTH-1:0] fu_sh,
  input  logic [DATA_WIDTH-1:0]    fu_result,
  input  logic                     fu_overflow,
  input  logic                     fu_carry,
  input  logic                     fu_negative,
  input  logic                     fu_zero,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_result,
  output logic [3:0]               rsp_flags,
  output logic                     busy
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [4:0] OP_MUL = 5'h10;

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL_ADD, S_MUL_SHL, S_RESP} state_t;

  state_t                   r_state, w_next;
  logic [4:0]               r_op;
  logic [DATA_WIDTH-1:0]    r_a, r_b, r_acc, r_mcand, r_mplier, r_result;
  logic [SHIFTER_WIDTH-1:0] r_sh;
  logic [CW-1:0]            r_count;
  logic [3:0]               r_flags;
  logic [CW-1:0]            w_count_inc;
  logic                     w_mul_more;

  assign w_count_inc = r_count + 1'b1;
  assign w_mul_more  = (w_count_inc < CW'(DATA_WIDTH));
  assign busy        = (r_state != S_IDLE);
  assign rsp_result  = r_result;
  assign rsp_flags   = r_flags;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    fu_sel    = 4'b0000;
    fu_a      = '0;
    fu_b      = '0;
    fu_sh     = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = (req_op == OP_MUL) ? S_MUL_ADD : S_EXEC;
      end
      S_EXEC: begin
        // Undefined opcodes 0x11-0x1F fall through as a single pass with the reserved select.
        fu_sel = r_op[4] ? 4'b1111 : r_op[3:0];
        fu_a   = r_a;
        fu_b   = r_b;
        fu_sh  = r_sh;
        w_next = S_RESP;
      end
      S_MUL_ADD: begin
        fu_sel = 4'b0010;
        fu_a   = r_acc;
        fu_b   = r_mcand;
        w_next = S_MUL_SHL;
      end
      S_MUL_SHL: begin
        fu_sel = 4'b1110;
        fu_a   = r_mcand;
        fu_sh  = SHIFTER_WIDTH'(1);
        w_next = w_mul_more ? S_MUL_ADD : S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_sh     <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op <= req_op;
            r_a  <= req_a;
            r_b  <= req_b;
            r_sh <= req_sh;
            if (req_op == OP_MUL) begin
              r_acc    <= '0;
              r_mcand  <= req_a;
              r_mplier <= req_b;
              r_count  <= '0;
            end
          end
        end
        S_EXEC: begin
          r_result <= fu_result;
          r_flags  <= {fu_overflow, fu_carry, fu_negative, fu_zero};
        end
        S_MUL_ADD: begin
          if (r_mplier[0]) r_acc <= fu_result;
        end
        S_MUL_SHL: begin
          r_mcand  <= fu_result;
          r_mplier <= r_mplier >> 1;
          r_count  <= w_count_inc;
          // acc is final once the last add step has run; the shift step never touches it.
          if (!w_mul_more) begin
            r_result <= r_acc;
            r_flags  <= {2'b00, r_acc[DATA_WIDTH-1], (r_acc == '0)};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
